// File: rtl/conv_mix_n_pkg.sv
// conv_mix_n_pkg
//   Shared types and constants for the conv_mix_n channel mixer.
//   Contents:
//     state_t            control FSM encoding (IDLE / WAIT / RUN)
//     DLY0_DEF/DLY1_DEF  default window-start delays (cycles)
//     NOUT0_DEF/NOUT1_DEF default output beats per frame
//     clog2()            ceiling log2, usable in parameter expressions
package conv_mix_n_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

   localparam int DLY0_DEF  = 10;
   localparam int DLY1_DEF  = 90;
   localparam int NOUT0_DEF = 576;
   localparam int NOUT1_DEF = 64;

   function automatic int clog2(input int val);
      int res;
      res = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < val) res = i + 1;
      end
      return res;
   endfunction

endpackage

// File: rtl/sat_add_tree.sv
// sat_add_tree
//   Registered pairwise adder tree over CH signed lanes, depth T = clog2(CH),
//   DW+T bits internally so no intermediate sum can overflow. The root is
//   clamped to the signed DW-bit range on the way out.
//   Ports:
//     clk   in   clock
//     rstn  in   synchronous active-low reset (clears all tree registers)
//     din   in   CH*DW packed signed lanes, lane k = din[k*DW +: DW]
//     sum   out  DW-bit saturated sum, valid T cycles after din
module sat_add_tree
   import conv_mix_n_pkg::*;
#(
   parameter int CH = 6,
   parameter int DW = 32
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [CH*DW-1:0] din,
   output logic [DW-1:0]    sum
);

   localparam int T  = clog2(CH);
   localparam int NP = 1 << T;
   localparam int SW = DW + T;

   localparam logic signed [SW-1:0] SAT_HI = {{(T+1){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [SW-1:0] SAT_LO = {{(T+1){1'b1}}, {(DW-1){1'b0}}};

   // Heap layout: tap[0..NP-2] are registered adder nodes, tap[NP-1..2NP-2]
   // are the sign-extended input leaves (zero-padded up to a power of two).
   logic signed [SW-1:0] node [NP-1];
   logic signed [SW-1:0] tap  [2*NP-1];

   for (genvar n = 0; n < NP - 1; n++) begin : g_node_tap
      assign tap[n] = node[n];
   end

   for (genvar i = 0; i < NP; i++) begin : g_leaf
      if (i < CH) begin : g_used
         assign tap[NP-1+i] = SW'($signed(din[i*DW +: DW]));
      end else begin : g_pad
         assign tap[NP-1+i] = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int n = 0; n < NP - 1; n++) node[n] <= '0;
      end else begin
         for (int n = 0; n < NP - 1; n++) node[n] <= tap[2*n+1] + tap[2*n+2];
      end
   end

   always_comb begin
      sum = tap[0][DW-1:0];
      if (tap[0] > SAT_HI)      sum = SAT_HI[DW-1:0];
      else if (tap[0] < SAT_LO) sum = SAT_LO[DW-1:0];
   end

endmodule

// File: rtl/conv_mix_n.sv
// conv_mix_n
//   Frame sequencer and output mixer for CH parallel convolution channels.
//   After start, waits DLY(mode) cycles before raising win_start, then accepts
//   beats only when every din_valid lane is set. Mode 0 passes each lane
//   through; mode 1 broadcasts the saturated cross-channel sum. Both paths
//   share T+1 cycles of latency and end in a registered ReLU.
//   Ports:
//     clk        in   clock
//     rstn       in   synchronous active-low reset
//     start      in   frame enable, held high for the frame
//     mode       in   0 = per-lane, 1 = summed broadcast (latched at frame start)
//     din_valid  in   CH per-lane valids
//     din        in   CH*DW packed signed lanes
//     win_start  out  high while in RUN
//     din_ready  out  copy of win_start
//     dout_valid out  output beat valid
//     dout       out  CH*DW ReLU outputs
//     done       out  one-cycle pulse after the last beat of a frame
//     align_err  out  sticky: din_valid seen partially set
//
//   state   | meaning
//   --------+----------------------------------------------------
//   IDLE    | waiting for start; mode latched on exit
//   WAIT    | counting DLY(mode_q) cycles before opening the window
//   RUN     | win_start high, beats accepted
module conv_mix_n
   import conv_mix_n_pkg::*;
#(
   parameter int CH    = 6,
   parameter int DW    = 32,
   parameter int DLY0  = DLY0_DEF,
   parameter int DLY1  = DLY1_DEF,
   parameter int NOUT0 = NOUT0_DEF,
   parameter int NOUT1 = NOUT1_DEF
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             start,
   input  logic             mode,
   input  logic [CH-1:0]    din_valid,
   input  logic [CH*DW-1:0] din,
   output logic             win_start,
   output logic             din_ready,
   output logic             dout_valid,
   output logic [CH*DW-1:0] dout,
   output logic             done,
   output logic             align_err
);

   localparam int T    = clog2(CH);
   localparam int DMAX = (DLY0 > DLY1) ? DLY0 : DLY1;
   localparam int NMAX = (NOUT0 > NOUT1) ? NOUT0 : NOUT1;
   localparam int DCW  = clog2(DMAX + 1);
   localparam int NCW  = clog2(NMAX + 1);

   state_t           state_q;
   state_t           state_d;
   logic             mode_q;
   logic [DCW-1:0]   dly_cnt;
   logic [DCW-1:0]   dly_tc;
   logic [NCW-1:0]   beat_cnt;
   logic [NCW-1:0]   nout_tc;
   logic             enter_wait;
   logic             all_v;
   logic             part_v;
   logic             accept;
   logic [T-1:0]     vld_pipe;
   logic [CH*DW-1:0] lane_dly [T];
   logic [DW-1:0]    tree_sum;
   logic [CH*DW-1:0] pre_relu;
   logic [CH*DW-1:0] relu_d;

   assign dly_tc     = mode_q ? DCW'(DLY1 - 1) : DCW'(DLY0 - 1);
   assign nout_tc    = mode_q ? NCW'(NOUT1 - 1) : NCW'(NOUT0 - 1);
   assign enter_wait = (state_q == ST_IDLE) && start;

   always_ff @(posedge clk) begin
      if (!rstn) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start) state_d = ST_WAIT;
         ST_WAIT: begin
            if (!start)                state_d = ST_IDLE;
            else if (dly_cnt == dly_tc) state_d = ST_RUN;
         end
         ST_RUN:  if (!start) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      win_start = (state_q == ST_RUN);
   end

   assign din_ready = win_start;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         dly_cnt <= '0;
         mode_q  <= 1'b0;
      end else if (enter_wait) begin
         dly_cnt <= '0;
         mode_q  <= mode;
      end else if (state_q == ST_WAIT) begin
         dly_cnt <= dly_cnt + 1'b1;
      end
   end

   assign all_v  = &din_valid;
   assign part_v = (|din_valid) && !all_v;
   assign accept = win_start && all_v;

   always_ff @(posedge clk) begin
      if (!rstn)       align_err <= 1'b0;
      else if (part_v) align_err <= 1'b1;
   end

   // Mode 0 lanes ride a T-deep delay line that matches the adder tree.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         vld_pipe <= '0;
         for (int i = 0; i < T; i++) lane_dly[i] <= '0;
      end else begin
         vld_pipe[0] <= accept;
         lane_dly[0] <= din;
         for (int i = 1; i < T; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            lane_dly[i] <= lane_dly[i-1];
         end
      end
   end

   sat_add_tree #(
      .CH (CH),
      .DW (DW)
   ) u_tree (
      .clk  (clk),
      .rstn (rstn),
      .din  (din),
      .sum  (tree_sum)
   );

   assign pre_relu = mode_q ? {CH{tree_sum}} : lane_dly[T-1];

   always_comb begin
      relu_d = '0;
      for (int k = 0; k < CH; k++) begin
         if (!pre_relu[k*DW+DW-1]) relu_d[k*DW +: DW] = pre_relu[k*DW +: DW];
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         dout_valid <= 1'b0;
         dout       <= '0;
      end else begin
         dout_valid <= vld_pipe[T-1];
         if (vld_pipe[T-1]) dout <= relu_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         beat_cnt <= '0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (enter_wait) begin
            beat_cnt <= '0;
         end else if (dout_valid) begin
            if (beat_cnt == nout_tc) begin
               beat_cnt <= '0;
               done     <= 1'b1;
            end else begin
               beat_cnt <= beat_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_conv_mix_n.sv
// tb_conv_mix_n
//   Directed bench for conv_mix_n with default parameters (CH=6, DW=32,
//   delays 10/90, frame lengths 576/64). Expected values are hand-computed.
module tb_conv_mix_n;

   localparam int CH = 6;
   localparam int DW = 32;

   typedef logic [CH*DW-1:0] vec_t;

   logic          clk = 1'b0;
   logic          rstn;
   logic          start;
   logic          mode;
   logic [CH-1:0] din_valid;
   vec_t          din;
   logic          win_start;
   logic          din_ready;
   logic          dout_valid;
   vec_t          dout;
   logic          done;
   logic          align_err;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   conv_mix_n dut (
      .clk        (clk),
      .rstn       (rstn),
      .start      (start),
      .mode       (mode),
      .din_valid  (din_valid),
      .din        (din),
      .win_start  (win_start),
      .din_ready  (din_ready),
      .dout_valid (dout_valid),
      .dout       (dout),
      .done       (done),
      .align_err  (align_err)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input vec_t obs, input vec_t exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   function automatic vec_t pk(input logic [31:0] l0, input logic [31:0] l1,
                               input logic [31:0] l2, input logic [31:0] l3,
                               input logic [31:0] l4, input logic [31:0] l5);
      return {l5, l4, l3, l2, l1, l0};
   endfunction

   function automatic vec_t rep(input logic [31:0] v);
      return {CH{v}};
   endfunction

   // Drops start, re-arms with mode m, and measures cycles from the first
   // start-high sampling edge until win_start rises.
   task automatic start_frame(input logic m, input int exp_dly, input bit flip, input string tag);
      int n;
      start = 1'b0;
      tick;
      tick;
      mode  = m;
      start = 1'b1;
      tick;
      if (flip) mode = ~m;
      n = 0;
      while (!win_start && n < 300) begin
         tick;
         n++;
      end
      chk({tag, " delay"}, vec_t'(n), vec_t'(exp_dly));
      chk({tag, " din_ready"}, vec_t'(din_ready), vec_t'(1));
   endtask

   task automatic beat(input vec_t d, input vec_t exp, input string tag);
      int lat;
      din       = d;
      din_valid = '1;
      tick;
      din_valid = '0;
      lat = 1;
      while (!dout_valid && lat < 12) begin
         tick;
         lat++;
      end
      chk({tag, " latency"}, vec_t'(lat), vec_t'(4));
      chk({tag, " data"}, dout, exp);
      tick;
      chk({tag, " dv drop"}, vec_t'(dout_valid), vec_t'(0));
   endtask

   task automatic burst(input int nb, input int nout, input string tag);
      int dv_cnt;
      int last_dv;
      int dones;
      int sent;
      din       = pk(1, 1, 1, 1, 1, 1);
      din_valid = '1;
      dv_cnt    = 0;
      last_dv   = -10;
      dones     = 0;
      sent      = 0;
      for (int t = 1; t <= nb + 20; t++) begin
         tick;
         if (sent < nb) begin
            sent++;
            if (sent == nb) din_valid = '0;
         end
         if (done) begin
            dones++;
            chk({tag, " done position"},
                vec_t'(((dv_cnt % nout) == 0) && (last_dv == t - 1)), vec_t'(1));
         end
         if (dout_valid) begin
            dv_cnt++;
            last_dv = t;
         end
      end
      chk({tag, " done count"}, vec_t'(dones), vec_t'(nb / nout));
      chk({tag, " dv count"}, vec_t'(dv_cnt), vec_t'(nb));
   endtask

   initial begin
      int cnt_dv;
      int cnt_done;
      int lat;

      rstn      = 1'b0;
      start     = 1'b0;
      mode      = 1'b0;
      din_valid = '0;
      din       = '0;
      tick;
      tick;
      chk("rst win_start", vec_t'(win_start), vec_t'(0));
      chk("rst din_ready", vec_t'(din_ready), vec_t'(0));
      chk("rst dout_valid", vec_t'(dout_valid), vec_t'(0));
      chk("rst done", vec_t'(done), vec_t'(0));
      chk("rst align_err", vec_t'(align_err), vec_t'(0));
      chk("rst dout", dout, vec_t'(0));
      rstn = 1'b1;

      // Mode 0: delay, lane passthrough with ReLU
      start_frame(1'b0, 10, 1'b0, "m0");
      beat(pk(5, -7, 32'h7FFFFFFF, -1, 123456, 32'h80000000),
           pk(5, 0, 32'h7FFFFFFF, 0, 123456, 0), "m0 lanes");
      beat(pk(0, 1, -2, 3, -4, 32'h40000000),
           pk(0, 1, 0, 3, 0, 32'h40000000), "m0 mixed");

      // Mode 0 full frame
      start_frame(1'b0, 10, 1'b0, "m0 frame");
      burst(576, 576, "m0 576");

      // Mode 1: delay, summed broadcast, saturation
      start_frame(1'b1, 90, 1'b0, "m1");
      beat(pk(1, 2, 3, 4, 5, -20), rep(0), "m1 neg sum");
      beat(pk(1, 2, 3, 4, 5, 6), rep(21), "m1 sum21");
      beat(rep(32'h7FFFFFFF), rep(32'h7FFFFFFF), "m1 sat hi");
      beat(pk(32'h7FFFFFFF, 1, -1, 0, 0, 0), rep(32'h7FFFFFFF), "m1 at max");
      beat(pk(32'h7FFFFFFF, 1, 0, 0, 0, 0), rep(32'h7FFFFFFF), "m1 max+1");
      beat(rep(32'h80000000), rep(0), "m1 sat lo");

      // Mode input flipped after latching: still mode 1 delay and frame length
      start_frame(1'b1, 90, 1'b1, "m1 flip");
      burst(128, 64, "m1 128");

      // Beat in flight when start falls still drains
      din       = pk(1, 2, 3, 4, 5, 6);
      din_valid = '1;
      tick;
      din_valid = '0;
      start     = 1'b0;
      tick;
      chk("drain win_start", vec_t'(win_start), vec_t'(0));
      lat = 2;
      while (!dout_valid && lat < 12) begin
         tick;
         lat++;
      end
      chk("drain latency", vec_t'(lat), vec_t'(4));
      chk("drain data", dout, rep(21));

      // Partial valid: flagged, dropped, sticky
      start_frame(1'b0, 10, 1'b0, "align");
      din       = pk(3, 3, 3, 3, 3, 3);
      din_valid = 6'b000111;
      tick;
      din_valid = '0;
      chk("align set", vec_t'(align_err), vec_t'(1));
      cnt_dv = 0;
      for (int i = 0; i < 8; i++) begin
         tick;
         if (dout_valid) cnt_dv++;
      end
      chk("align dropped", vec_t'(cnt_dv), vec_t'(0));
      chk("align sticky", vec_t'(align_err), vec_t'(1));

      // Reset with a beat in flight
      din       = pk(9, 9, 9, 9, 9, 9);
      din_valid = '1;
      tick;
      din_valid = '0;
      tick;
      rstn = 1'b0;
      tick;
      chk("midrst dout_valid", vec_t'(dout_valid), vec_t'(0));
      chk("midrst done", vec_t'(done), vec_t'(0));
      chk("midrst win_start", vec_t'(win_start), vec_t'(0));
      chk("midrst din_ready", vec_t'(din_ready), vec_t'(0));
      chk("midrst align_err", vec_t'(align_err), vec_t'(0));
      chk("midrst dout", dout, vec_t'(0));
      rstn = 1'b1;
      cnt_dv   = 0;
      cnt_done = 0;
      for (int i = 0; i < 6; i++) begin
         tick;
         if (dout_valid) cnt_dv++;
         if (done) cnt_done++;
      end
      chk("midrst no dv", vec_t'(cnt_dv), vec_t'(0));
      chk("midrst no done", vec_t'(cnt_done), vec_t'(0));
      start_frame(1'b0, 10, 1'b0, "rerun");
      beat(pk(-3, 4, 0, 32'h7FFFFFFE, -100, 77),
           pk(0, 4, 0, 32'h7FFFFFFE, 0, 77), "rerun lanes");

      start = 1'b0;
      tick;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/conv_mix_n.md
CONV_MIX_N -- requirements
Module: conv_mix_n

Interface
REQ-001 Parameter CH, default 6: number of convolution channels, range 2..16.
REQ-002 Parameter DW, default 32: signed data width per channel.
REQ-003 Parameter DLY0, default 10: window-start delay in cycles, mode 0.
REQ-004 Parameter DLY1, default 90: window-start delay in cycles, mode 1.
REQ-005 Parameter NOUT0, default 576: output beats per frame, mode 0.
REQ-006 Parameter NOUT1, default 64: output beats per frame, mode 1.
REQ-007 The block has one clock; reset is synchronous and active-low.
REQ-008 clk  in  1  clock; all logic samples on its rising edge.
REQ-009 rstn  in  1  reset, synchronous, active-low.
REQ-010 start  in  1  frame enable; held high for the whole frame.
REQ-011 mode  in  1  0 = per-channel outputs, 1 = cross-channel sum broadcast on all lanes.
REQ-012 din_valid  in  CH  per-channel conv result valid.
REQ-013 din  in  CH*DW  signed conv results; lane k is bits [k*DW +: DW].
REQ-014 win_start  out  1  start strobe level for the sliding-window instances.
REQ-015 din_ready  out  1  equals win_start.
REQ-016 dout_valid  out  1  output beat valid.
REQ-017 dout  out  CH*DW  ReLU outputs, same lane packing as din.
REQ-018 done  out  1  one-cycle end-of-frame pulse.
REQ-019 align_err  out  1  sticky flag: din_valid was partially set.

Function
REQ-020 The control FSM SHALL have states IDLE, WAIT and RUN.
REQ-021 In IDLE, start=1 SHALL move to WAIT, latch mode into mode_q, and clear the delay counter.
REQ-022 In WAIT, the FSM SHALL move to RUN after exactly DLY(mode_q) cycles, so win_start rises DLY cycles after the first start-high sample.
REQ-023 win_start SHALL be 1 only in RUN.
REQ-024 start=0 in WAIT or RUN SHALL return the FSM to IDLE on the next cycle.
REQ-025 mode changes while the FSM is not in IDLE SHALL be ignored.
REQ-026 A beat SHALL be accepted only when din_valid is all ones.
REQ-027 Any cycle with din_valid neither all zeros nor all ones SHALL set align_err; that beat SHALL be dropped.
REQ-028 In mode 1, the CH lanes SHALL be summed by a registered pairwise adder tree of depth T = ceil(log2 CH).
REQ-029 The adder tree SHALL be DW + T bits wide internally.
REQ-030 Sums above 2^(DW-1)-1 SHALL saturate to 2^(DW-1)-1; no wrap-around.
REQ-031 In mode 0, each lane SHALL be delayed T registers so latency is identical in both modes.
REQ-032 ReLU SHALL be one registered stage: a negative value (MSB set) outputs 0, otherwise the value passes unchanged.
REQ-033 Latency SHALL be T+1 cycles from an accepted beat to dout_valid=1, in both modes.
REQ-034 dout_valid SHALL follow the accepted-beat valid through the same pipeline and SHALL NOT be sticky.
REQ-035 In mode 1, all CH dout lanes SHALL carry the same saturated, ReLU'd sum.
REQ-036 A beat counter SHALL increment on each dout_valid.
REQ-037 When the counter reaches NOUT(mode_q), done SHALL pulse for the next cycle and the counter SHALL clear.
REQ-038 Beats in flight when start falls SHALL still drain to dout.
REQ-039 The beat counter SHALL clear when the FSM enters WAIT.

Reset
REQ-040 With rstn=0 at a clock edge: FSM=IDLE; all counters=0; win_start, din_ready, dout_valid, done, align_err = 0; dout=0; pipeline valids=0.
REQ-041 Reset mid-frame SHALL discard all in-flight beats; no done pulse follows.
REQ-042 align_err SHALL clear only on reset.

Structure
REQ-043 A shared package SHALL hold the FSM state encoding, the default delays (10/90), the default beat counts (576/64), and a clog2 helper constant function.
REQ-044 Sub-module sat_add_tree SHALL implement REQ-028 to REQ-030, parametrised by CH and DW.
REQ-045 The target size of conv_mix_n is 120-400 RTL lines.

Verification
REQ-046 Mode 0, start held high -> win_start rises exactly 10 cycles after start is first sampled; mode 1 -> 90 cycles.
REQ-047 CH=6, mode 1, lanes 1,2,3,4,5,-20 with all valid -> dout_valid 4 cycles later, every lane = 0 (sum -5, ReLU'd); lanes 1..6 -> every lane = 21.
REQ-048 Mode 1, six lanes of 0x7FFFFFFF -> every lane = 0x7FFFFFFF (saturated, not wrapped).
REQ-049 Mode 0, 576 consecutive valid beats -> done pulses once, 1 cycle after the 576th dout_valid; counter returns to 0.
REQ-050 din_valid=6'b000111 for one cycle -> align_err=1, no dout_valid for that beat, align_err stays 1 until rstn=0.
REQ-051 Assert rstn=0 in RUN with beats in flight -> next cycle all outputs 0, no done pulse, and a new start reruns the full delay.
